// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Two-master to one-slave arbiter sitting between the core wrapper's
// instruction (m0) and data (m1) memory ports and a single-port on-chip
// SRAM. Read data and response-valid always arrive exactly one cycle after
// the ready (grant) cycle. Arbitration is round-robin, or data-priority
// with a starvation guard that forces m0 after MAX_WAIT lost cycles.
//
// Parameters
//   ABITS       address width of all ports
//   FIXED_PRIO  0 = round-robin, 1 = m1 wins ties (subject to MAX_WAIT)
//   MAX_WAIT    consecutive losing cycles of m0 before it is forced, 1..255
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   mX_valid/mX_ready          master request / accepted this cycle
//   mX_addr/write_en/byte_en/wdata  master request payload
//   mX_rdata/mX_rvalid         response for the access accepted last cycle
//   s_valid/s_ready            slave request / slave accepts
//   s_addr/write_en/byte_en/wdata   payload muxed from the granted master
//   s_rdata                    SRAM read data, valid the cycle after handshake
// ---------------------------------------------------------------------------
`ifndef ABITS
`define ABITS 32
`endif

module mem_port_arbiter #(
  parameter int ABITS      = `ABITS,
  parameter bit FIXED_PRIO = 1'b0,
  parameter int MAX_WAIT   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_valid,
  output logic             m0_ready,
  input  logic [ABITS-1:0] m0_addr,
  input  logic             m0_write_en,
  input  logic [3:0]       m0_byte_en,
  input  logic [31:0]      m0_wdata,
  output logic [31:0]      m0_rdata,
  output logic             m0_rvalid,
  input  logic             m1_valid,
  output logic             m1_ready,
  input  logic [ABITS-1:0] m1_addr,
  input  logic             m1_write_en,
  input  logic [3:0]       m1_byte_en,
  input  logic [31:0]      m1_wdata,
  output logic [31:0]      m1_rdata,
  output logic             m1_rvalid,
  output logic             s_valid,
  input  logic             s_ready,
  output logic [ABITS-1:0] s_addr,
  output logic             s_write_en,
  output logic [3:0]       s_byte_en,
  output logic [31:0]      s_wdata,
  input  logic [31:0]      s_rdata
);

  localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);

  logic       last_grant;  // master granted at the most recent handshake
  logic       hold_valid;  // slave stalled: grant is locked
  logic       hold_idx;    // master the grant is locked to
  logic [7:0] wait_cnt;    // consecutive cycles m0 waited without handshake
  logic       resp_pend;   // a handshake happened last cycle
  logic       resp_owner;  // master that owns the pending response
  logic       resp_read;   // pending response belongs to a read

  logic grant;
  logic hs;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = 1'b0;
    if (hold_valid) begin
      grant = hold_idx;
    end else if (m0_valid && !m1_valid) begin
      grant = 1'b0;
    end else if (!m0_valid && m1_valid) begin
      grant = 1'b1;
    end else if (m0_valid && m1_valid) begin
      if (FIXED_PRIO) grant = (wait_cnt == MAX_W8) ? 1'b0 : 1'b1;
      else            grant = ~last_grant;
    end
  end

  assign s_valid = m0_valid | m1_valid;
  assign hs      = s_valid & s_ready;

  // Grant is 0 whenever s_valid is 0, so the idle slave bus shows m0.
  assign s_addr     = grant ? m1_addr     : m0_addr;
  assign s_write_en = grant ? m1_write_en : m0_write_en;
  assign s_byte_en  = grant ? m1_byte_en  : m0_byte_en;
  assign s_wdata    = grant ? m1_wdata    : m0_wdata;

  assign m0_ready = hs & ~grant;
  assign m1_ready = hs &  grant;

  assign m0_rvalid = resp_pend & ~resp_owner;
  assign m1_rvalid = resp_pend &  resp_owner;
  assign m0_rdata  = (m0_rvalid && resp_read) ? s_rdata : 32'h0;
  assign m1_rdata  = (m1_rvalid && resp_read) ? s_rdata : 32'h0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;  // m0 wins the first tie after reset
      hold_valid <= 1'b0;
      hold_idx   <= 1'b0;
      wait_cnt   <= 8'd0;
      resp_pend  <= 1'b0;  // drops any response in flight
      resp_owner <= 1'b0;
      resp_read  <= 1'b0;
    end else begin
      // Lock the grant across a slave stall so a late higher-priority
      // request cannot switch the slave mid-transfer.
      if (s_valid && !s_ready) begin
        hold_valid <= 1'b1;
        hold_idx   <= grant;
      end else if (hs) begin
        hold_valid <= 1'b0;
        last_grant <= grant;
      end

      resp_pend <= hs;
      if (hs) begin
        resp_owner <= grant;
        resp_read  <= ~s_write_en;
      end

      if (!m0_valid || m0_ready) wait_cnt <= 8'd0;
      else if (wait_cnt != MAX_W8) wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule
